// File: rtl/matmul_mac_pkg.sv
// Shared constants, beat tag payload and operand extension helper for the
// matrix-multiply MAC pipeline.
package matmul_mac_pkg;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_MAC = 1'b1;

   // Legal NUM_STAGE range is 1..MAX_STAGE.
   localparam int unsigned MAX_STAGE = 6;

   // Widest value mac_ext can handle; must cover DIN0+DIN1+1 and DOUT widths.
   localparam int unsigned EXT_MAX = 128;

   typedef struct packed {
      logic mode;
      logic last;
   } beat_tag_t;

   // Keep the low 'width' bits of value and fill above with sign or zero.
   function automatic logic [EXT_MAX-1:0] mac_ext(input logic [EXT_MAX-1:0] value,
                                                  input int unsigned       width,
                                                  input logic              is_signed);
      logic [EXT_MAX-1:0] mask;
      logic [EXT_MAX-1:0] msb;
      logic               sb;
      mask = (width >= EXT_MAX) ? '1 : ((EXT_MAX'(1) << width) - EXT_MAX'(1));
      msb  = value >> (width - 1);
      sb   = is_signed & msb[0];
      return (value & mask) | (sb ? ~mask : '0);
   endfunction

endpackage

// File: rtl/matmul_mac_pipe_mul_core.sv
// Combinational extend-and-multiply: exact product of the extended operands,
// resized to the result width.
module matmul_mul_core
   import matmul_mac_pkg::*;
#(
   parameter int unsigned DIN0_WIDTH  = 32,
   parameter int unsigned DIN1_WIDTH  = 28,
   parameter int unsigned DOUT_WIDTH  = 32,
   parameter int unsigned DIN0_SIGNED = 1,
   parameter int unsigned DIN1_SIGNED = 0
) (
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic [DOUT_WIDTH-1:0] prod
);

   localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH + 1;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] p_full;

   assign a_ext  = PW'(mac_ext(EXT_MAX'(din0), DIN0_WIDTH, DIN0_SIGNED != 0));
   assign b_ext  = PW'(mac_ext(EXT_MAX'(din1), DIN1_WIDTH, DIN1_SIGNED != 0));
   // PW bits hold the exact product of any operand pair.
   assign p_full = a_ext * b_ext;
   assign prod   = DOUT_WIDTH'(mac_ext(EXT_MAX'(p_full), PW,
                                       (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0)));

endmodule

// File: rtl/matmul_mac_pipe.sv
// Pipelined mixed-sign multiplier / dot-product accumulator with valid/ready
// flow control; one stall enable freezes every stage.
module matmul_mac_pipe
   import matmul_mac_pkg::*;
#(
   parameter int unsigned DIN0_WIDTH  = 32,
   parameter int unsigned DIN1_WIDTH  = 28,
   parameter int unsigned DOUT_WIDTH  = 32,
   parameter int unsigned DIN0_SIGNED = 1,
   parameter int unsigned DIN1_SIGNED = 0,
   parameter int unsigned NUM_STAGE   = 3
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  in_mode,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout
);

   logic                  stall;
   logic                  accept;
   logic [DOUT_WIDTH-1:0] prod_c;
   logic                  tail_valid;
   beat_tag_t             tail_tag;
   logic [DOUT_WIDTH-1:0] tail_prod;
   logic [DOUT_WIDTH-1:0] acc;
   logic [DOUT_WIDTH-1:0] acc_sum_c;
   logic                  run_open;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   matmul_mul_core #(
      .DIN0_WIDTH  (DIN0_WIDTH),
      .DIN1_WIDTH  (DIN1_WIDTH),
      .DOUT_WIDTH  (DOUT_WIDTH),
      .DIN0_SIGNED (DIN0_SIGNED),
      .DIN1_SIGNED (DIN1_SIGNED)
   ) u_core (
      .din0 (din0),
      .din1 (din1),
      .prod (prod_c)
   );

   generate
      if (NUM_STAGE <= 1) begin : g_comb
         assign tail_valid = accept;
         assign tail_tag   = '{mode: in_mode, last: in_last};
         assign tail_prod  = prod_c;
      end else begin : g_pipe
         localparam int unsigned NP = NUM_STAGE - 1;

         logic [NP-1:0]         v_q;
         beat_tag_t             tag_q  [NP];
         logic [DOUT_WIDTH-1:0] prod_q [NP];

         // Valid bits are the only pipeline state that reset must clear.
         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               v_q <= '0;
            end else if (!stall) begin
               v_q[0] <= accept;
               for (int i = 1; i < int'(NP); i++) begin
                  v_q[i] <= v_q[i-1];
               end
            end
         end

         always_ff @(posedge ap_clk) begin
            if (!stall) begin
               tag_q[0]  <= '{mode: in_mode, last: in_last};
               prod_q[0] <= prod_c;
               for (int i = 1; i < int'(NP); i++) begin
                  tag_q[i]  <= tag_q[i-1];
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign tail_valid = v_q[NP-1];
         assign tail_tag   = tag_q[NP-1];
         assign tail_prod  = prod_q[NP-1];
      end
   endgenerate

   // A closed run restarts from zero rather than the stale sum.
   assign acc_sum_c = (run_open ? acc : '0) + tail_prod;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         acc       <= '0;
         run_open  <= 1'b0;
      end else if (!stall) begin
         out_valid <= 1'b0;
         if (tail_valid) begin
            if (tail_tag.mode == MODE_MUL) begin
               dout      <= tail_prod;
               out_valid <= 1'b1;
            end else begin
               acc      <= acc_sum_c;
               run_open <= !tail_tag.last;
               if (tail_tag.last) begin
                  dout      <= acc_sum_c;
                  out_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_matmul_mac_pipe.sv
// Scoreboard bench: default build plus NUM_STAGE=1/signed-B and NUM_STAGE=6
// builds fed the same accepted beat stream.
module tb_matmul_mac_pipe;
   import matmul_mac_pkg::*;

   typedef struct {
      logic [31:0] v;
      int          cyc;
      bit          chk;
   } exp_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        drv_valid = 1'b0;
   logic        in_mode = 1'b0;
   logic        in_last = 1'b0;
   logic        ordy = 1'b1;
   logic [31:0] din0 = '0;
   logic [27:0] din1 = '0;
   logic [31:0] exp_d = '0;
   logic [31:0] exp_s = '0;
   bit          emit = 0;
   bit          lat_chk = 1;

   logic        rdy0, rdy1, rdy6, ov0, ov1, ov6;
   logic [31:0] do0, do1, do6;
   logic        sec_valid;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q6[$];

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   // Secondary builds never stall, so they only take beats the main DUT takes.
   assign sec_valid = drv_valid && rdy0;

   matmul_mac_pipe u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(drv_valid), .in_ready(rdy0),
      .din0(din0), .din1(din1), .in_mode(in_mode), .in_last(in_last),
      .out_valid(ov0), .out_ready(ordy), .dout(do0));

   matmul_mac_pipe #(.DIN1_SIGNED(1), .NUM_STAGE(1)) u_s1 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(sec_valid), .in_ready(rdy1),
      .din0(din0), .din1(din1), .in_mode(in_mode), .in_last(in_last),
      .out_valid(ov1), .out_ready(1'b1), .dout(do1));

   matmul_mac_pipe #(.NUM_STAGE(6)) u_s6 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(sec_valid), .in_ready(rdy6),
      .din0(din0), .din1(din1), .in_mode(in_mode), .in_last(in_last),
      .out_valid(ov6), .out_ready(1'b1), .dout(do6));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Issue one beat at posedge+1; returns posedge+1 after it was accepted.
   task automatic send(input logic [31:0] a, input logic [27:0] b, input logic m,
                       input logic l, input logic [31:0] ed, input logic [31:0] es);
      int n;
      bit ok;
      drv_valid = 1'b1; din0 = a; din1 = b; in_mode = m; in_last = l;
      exp_d = ed; exp_s = es; emit = (m == MODE_MUL) || l;
      n = 0; ok = 0;
      while (!ok && n < 200) begin
         @(negedge ap_clk);
         ok = rdy0;
         @(posedge ap_clk);
         #1;
         n++;
      end
      if (!ok) fail_now("send_timeout");
      drv_valid = 1'b0; emit = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   // Record the expected response at the moment a result-producing beat is accepted.
   always @(negedge ap_clk) begin
      if (!ap_rst && drv_valid && rdy0 && emit) begin
         q0.push_back('{v: exp_d, cyc: cyc, chk: lat_chk});
         q1.push_back('{v: exp_s, cyc: cyc, chk: 1'b1});
         q6.push_back('{v: exp_d, cyc: cyc, chk: 1'b1});
      end
   end

   logic        stalled_prev = 1'b0;
   logic [31:0] held = '0;

   always @(negedge ap_clk) begin : mon_main
      exp_t e;
      if (ap_rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev) begin
            chk("main_hold_valid", 32'(ov0), 32'd1);
            chk("main_hold_dout", do0, held);
         end
         if (ov0 && !ordy) begin
            chk("main_in_ready_stall", 32'(rdy0), 32'd0);
            stalled_prev = 1'b1;
            held = do0;
         end else begin
            stalled_prev = 1'b0;
         end
         if (ov0 && ordy) begin
            if (q0.size() == 0) begin
               fail_now($sformatf("main_unexpected dout=%h", do0));
            end else begin
               e = q0.pop_front();
               chk("main_dout", do0, e.v);
               if (e.chk) chk("main_latency", 32'(cyc - e.cyc), 32'd3);
            end
         end
      end
   end

   always @(negedge ap_clk) begin : mon_s1
      exp_t e;
      if (!ap_rst && ov1) begin
         if (q1.size() == 0) begin
            fail_now($sformatf("s1_unexpected dout=%h", do1));
         end else begin
            e = q1.pop_front();
            chk("s1_dout", do1, e.v);
            chk("s1_latency", 32'(cyc - e.cyc), 32'd1);
         end
      end
   end

   always @(negedge ap_clk) begin : mon_s6
      exp_t e;
      if (!ap_rst && ov6) begin
         if (q6.size() == 0) begin
            fail_now($sformatf("s6_unexpected dout=%h", do6));
         end else begin
            e = q6.pop_front();
            chk("s6_dout", do6, e.v);
            chk("s6_latency", 32'(cyc - e.cyc), 32'd6);
         end
      end
   end

   initial begin
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("rst_main_in_ready", 32'(rdy0), 32'd1);
      chk("rst_main_out_valid", 32'(ov0), 32'd0);
      chk("rst_main_dout", do0, 32'd0);
      chk("rst_s1_in_ready", 32'(rdy1), 32'd1);
      chk("rst_s1_out_valid", 32'(ov1), 32'd0);
      chk("rst_s1_dout", do1, 32'd0);
      chk("rst_s6_in_ready", 32'(rdy6), 32'd1);
      chk("rst_s6_out_valid", 32'(ov6), 32'd0);
      chk("rst_s6_dout", do6, 32'd0);
      @(posedge ap_clk);
      #1;

      // Signed A times unsigned B: -3 * 5
      send(32'hFFFF_FFFD, 28'd5, MODE_MUL, 1'b0, 32'hFFFF_FFF1, 32'hFFFF_FFF1);
      idle(8);
      // B top bit: +2^27 unsigned, -2^27 when B is signed
      send(32'd2, 28'h800_0000, MODE_MUL, 1'b0, 32'h1000_0000, 32'hF000_0000);
      idle(8);

      // Back-to-back MUL stream with boundary operands
      send(32'hFFFF_FFFF, 28'hFFF_FFFF, MODE_MUL, 1'b0, 32'hF000_0001, 32'h0000_0001);
      send(32'h8000_0000, 28'hFFF_FFFF, MODE_MUL, 1'b0, 32'h8000_0000, 32'h8000_0000);
      send(32'hFFFF_FFFD, 28'd5,        MODE_MUL, 1'b0, 32'hFFFF_FFF1, 32'hFFFF_FFF1);
      send(32'd2,         28'h800_0000, MODE_MUL, 1'b0, 32'h1000_0000, 32'hF000_0000);
      idle(10);

      // MAC run 6 + 20 - 7 = 19, then a fresh single-beat run
      send(32'd2, 28'd3, MODE_MAC, 1'b0, 32'd0, 32'd0);
      send(32'd4, 28'd5, MODE_MAC, 1'b0, 32'd0, 32'd0);
      send(32'hFFFF_FFFF, 28'd7, MODE_MAC, 1'b1, 32'd19, 32'd19);
      idle(8);
      send(32'd1, 28'd1, MODE_MAC, 1'b1, 32'd1, 32'd1);
      idle(8);

      // MUL inside an open run leaves the sum alone: 9 + 4 = 13
      send(32'd3, 28'd3, MODE_MAC, 1'b0, 32'd0, 32'd0);
      send(32'd2, 28'd2, MODE_MUL, 1'b0, 32'd4, 32'd4);
      send(32'd1, 28'd4, MODE_MAC, 1'b1, 32'd13, 32'd13);
      idle(8);

      // Backpressure: hold out_ready low 5 cycles from the first result
      lat_chk = 0;
      fork
         begin
            send(32'd1, 28'd10, MODE_MUL, 1'b0, 32'd10,  32'd10);
            send(32'd2, 28'd11, MODE_MUL, 1'b0, 32'd22,  32'd22);
            send(32'd3, 28'd12, MODE_MUL, 1'b0, 32'd36,  32'd36);
            send(32'd4, 28'd13, MODE_MUL, 1'b0, 32'd52,  32'd52);
            send(32'd5, 28'd14, MODE_MUL, 1'b0, 32'd70,  32'd70);
            send(32'd6, 28'd15, MODE_MUL, 1'b0, 32'd90,  32'd90);
            send(32'd7, 28'd16, MODE_MUL, 1'b0, 32'd112, 32'd112);
            send(32'd8, 28'd17, MODE_MUL, 1'b0, 32'd136, 32'd136);
         end
         begin
            int n;
            n = 0;
            while (!ov0 && n < 50) begin
               @(posedge ap_clk);
               #1;
               n++;
            end
            if (!ov0) fail_now("bp_first_result_timeout");
            ordy = 1'b0;
            repeat (5) @(posedge ap_clk);
            #1;
            ordy = 1'b1;
         end
      join
      idle(15);
      lat_chk = 1;

      // Reset in the middle of an open run discards it
      send(32'd5, 28'd5, MODE_MAC, 1'b0, 32'd0, 32'd0);
      send(32'd7, 28'd7, MODE_MAC, 1'b0, 32'd0, 32'd0);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      send(32'd6, 28'd6, MODE_MAC, 1'b1, 32'd36, 32'd36);
      idle(10);

      chk("main_queue_empty", 32'(q0.size()), 32'd0);
      chk("s1_queue_empty", 32'(q1.size()), 32'd0);
      chk("s6_queue_empty", 32'(q6.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
